// File: rtl/keccak_lane_serializer.sv
// Unpacks 256-bit state words into a stream of 64-bit Keccak lanes, each tagged
// with its (x, y) coordinate and a last-lane flag.
module keccak_lane_serializer #(
    parameter int NumLanes = 25
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         word_valid_i,
    output logic         word_ready_o,
    input  logic [255:0] word_i,
    output logic         lane_valid_o,
    input  logic         lane_ready_i,
    output logic [63:0]  lane_o,
    output logic [2:0]   lane_x_o,
    output logic [2:0]   lane_y_o,
    output logic         lane_last_o,
    output logic         busy_o,
    output logic         done_o
);

    // state | meaning
    // IDLE  | no stream; waits for start_i
    // LOAD  | buffer empty; waits for the next word
    // EMIT  | buffer holds a word; presents lane at slot_q
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    localparam int IdxW = 5;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLanes - 1);

    state_e          state_q, state_d;
    logic [255:0]    buf_q, buf_d;
    logic [1:0]      slot_q, slot_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [2:0]      x_q, x_d;
    logic [2:0]      y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            is_last;
    logic            slot_end;
    logic [63:0]     lane_sel;

    assign is_last  = (idx_q == LastIdx);
    assign slot_end = (slot_q == 2'd3);
    assign lane_sel = buf_q[{slot_q, 6'd0} +: 64];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            slot_q  <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        slot_d       = slot_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        word_ready_o = 1'b0;
        lane_valid_o = 1'b0;

        if (start_i) begin
            // Abort/restart wins over any handshake in this cycle.
            state_d = ST_LOAD;
            buf_d   = '0;
            slot_d  = '0;
            idx_d   = '0;
            x_d     = '0;
            y_d     = '0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LOAD: begin
                    word_ready_o = 1'b1;
                    if (word_valid_i) begin
                        buf_d   = word_i;
                        slot_d  = '0;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    lane_valid_o = 1'b1;
                    if (lane_ready_i) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            slot_d = slot_q + 2'd1;
                            if (x_q == 3'd4) begin
                                x_d = '0;
                                y_d = y_q + 3'd1;
                            end else begin
                                x_d = x_q + 3'd1;
                            end
                            // Refill in the same cycle so back-to-back words have no bubble.
                            if (slot_end) begin
                                word_ready_o = 1'b1;
                                if (word_valid_i) begin
                                    buf_d = word_i;
                                end else begin
                                    state_d = ST_LOAD;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign lane_o      = lane_valid_o ? lane_sel : 64'd0;
    assign lane_x_o    = lane_valid_o ? x_q : 3'd0;
    assign lane_y_o    = lane_valid_o ? y_q : 3'd0;
    assign lane_last_o = lane_valid_o & is_last;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_keccak_lane_serializer.sv
// Scoreboard bench for keccak_lane_serializer: a 25-lane and a 4-lane instance,
// expected lanes derived from the words by index arithmetic.
module tb_keccak_lane_serializer;

    typedef struct packed {
        logic [63:0] lane;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
    } exp_t;

    logic         clk_i;
    logic         rst_i;
    logic         start_a [2];
    logic         wv_a    [2];
    logic [255:0] word_i;
    logic         lane_ready_i;
    logic         wr_a    [2];
    logic         lv_a    [2];
    logic [63:0]  lane_a  [2];
    logic [2:0]   lx_a    [2];
    logic [2:0]   ly_a    [2];
    logic         ll_a    [2];
    logic         busy_a  [2];
    logic         done_a  [2];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   sel = 0;
    exp_t exp_q[$];
    int   mon_cnt = 0;
    bit   done_exp = 0;
    bit   done_seen = 0;
    bit   have_hold = 0;
    int   first_cyc, last_cyc, done_cyc, acc_cyc;
    int   mnl;
    exp_t e;
    logic [63:0] h_lane;
    logic [2:0]  h_x, h_y;
    logic        h_last;
    logic        exp_wr;

    keccak_lane_serializer #(.NumLanes(25)) u_dut25 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_a[0]),
        .word_valid_i(wv_a[0]), .word_ready_o(wr_a[0]), .word_i(word_i),
        .lane_valid_o(lv_a[0]), .lane_ready_i(lane_ready_i), .lane_o(lane_a[0]),
        .lane_x_o(lx_a[0]), .lane_y_o(ly_a[0]), .lane_last_o(ll_a[0]),
        .busy_o(busy_a[0]), .done_o(done_a[0])
    );

    keccak_lane_serializer #(.NumLanes(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_a[1]),
        .word_valid_i(wv_a[1]), .word_ready_o(wr_a[1]), .word_i(word_i),
        .lane_valid_o(lv_a[1]), .lane_ready_i(lane_ready_i), .lane_o(lane_a[1]),
        .lane_x_o(lx_a[1]), .lane_y_o(ly_a[1]), .lane_last_o(ll_a[1]),
        .busy_o(busy_a[1]), .done_o(done_a[1])
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops one expected lane per lane handshake on the selected instance.
    always @(negedge clk_i) begin
        mnl = (sel == 1) ? 4 : 25;
        if (rst_i) begin
            exp_q.delete();
            mon_cnt   = 0;
            done_exp  = 0;
            have_hold = 0;
        end else begin
            chk("done_pulse", 64'(done_a[sel]), 64'(done_exp));
            if (done_a[sel]) begin
                chk("busy_fall", 64'(busy_a[sel]), 64'd0);
                done_seen = 1;
                done_cyc  = cyc;
            end
            done_exp = 0;
            if (start_a[sel]) begin
                chk("start_quiet", {62'd0, lv_a[sel], wr_a[sel]}, 64'd0);
                exp_q.delete();
                mon_cnt   = 0;
                have_hold = 0;
            end else begin
                if (have_hold) begin
                    chk("stall_hold", 64'(lv_a[sel] && lane_a[sel] == h_lane && lx_a[sel] == h_x
                                         && ly_a[sel] == h_y && ll_a[sel] == h_last), 64'd1);
                    have_hold = 0;
                end
                if (lv_a[sel]) begin
                    chk("busy_high", 64'(busy_a[sel]), 64'd1);
                    exp_wr = lane_ready_i && (mon_cnt % 4 == 3) && (mon_cnt != mnl - 1);
                    chk("word_ready_emit", 64'(wr_a[sel]), 64'(exp_wr));
                    if (lane_ready_i) begin
                        if (exp_q.size() == 0) begin
                            chk("extra_lane", 64'(exp_q.size()), 64'd1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("lane", lane_a[sel], e.lane);
                            chk("lane_xy", {58'd0, lx_a[sel], ly_a[sel]}, {58'd0, e.x, e.y});
                            chk("lane_last", 64'(ll_a[sel]), 64'(e.last));
                            if (mon_cnt == 0) first_cyc = cyc;
                            if (e.last) begin
                                done_exp = 1;
                                last_cyc = cyc;
                            end
                        end
                        mon_cnt++;
                    end else begin
                        have_hold = 1;
                        h_lane = lane_a[sel];
                        h_x    = lx_a[sel];
                        h_y    = ly_a[sel];
                        h_last = ll_a[sel];
                    end
                end
            end
        end
    end

    task automatic run_stream(input int sel_in, input bit pattern, input bit lr_rand,
                              input bit wv_rand, input int abort_idx_in, input int rst_idx,
                              input bit timing);
        logic [255:0] words [8];
        int  nl, nw, wptr, abort_idx;
        bit  wfire, chk_load, stop;
        exp_t pe;
        sel       = sel_in;
        nl        = (sel_in == 1) ? 4 : 25;
        nw        = (nl + 3) / 4;
        abort_idx = abort_idx_in;
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < 4; k++)
                words[w][64*k +: 64] = pattern ? (64'h100 * 64'(w) + 64'(k))
                                               : {$urandom, $urandom};
        @(posedge clk_i); #1;
        start_a[sel]  = 1'b1;
        wv_a[sel]     = 1'b0;
        lane_ready_i  = 1'b0;
        wptr          = 0;
        acc_cyc       = -1;
        done_seen     = 0;
        chk_load      = 0;
        stop          = 0;
        for (int c = 0; c < 3000 && !done_seen && !stop; c++) begin
            @(negedge clk_i);
            if (chk_load) begin
                chk("load_ready", 64'(wr_a[sel]), 64'd1);
                chk("busy_rise", 64'(busy_a[sel]), 64'd1);
                chk_load = 0;
            end
            wfire = wv_a[sel] && wr_a[sel];
            if (wfire && acc_cyc < 0) acc_cyc = cyc;
            @(posedge clk_i); #1;
            if (start_a[sel]) begin
                start_a[sel] = 1'b0;
                chk_load = 1;
                wptr = 0;
                acc_cyc = -1;
                for (int i = 0; i < nl; i++) begin
                    pe.lane = words[i / 4][64*(i % 4) +: 64];
                    pe.x    = 3'(i % 5);
                    pe.y    = 3'(i / 5);
                    pe.last = (i == nl - 1);
                    exp_q.push_back(pe);
                end
            end else if (wfire) begin
                wptr++;
            end
            wv_a[sel]    = (wptr < nw) && (!wv_rand || $urandom_range(0, 1) == 1);
            word_i       = words[(wptr < nw) ? wptr : 0];
            lane_ready_i = !lr_rand || $urandom_range(0, 1) == 1;
            if (abort_idx >= 0 && mon_cnt == abort_idx && lv_a[sel]) begin
                lane_ready_i = 1'b0;
                wv_a[sel]    = 1'b0;
                start_a[sel] = 1'b1;
                abort_idx    = -1;
                for (int w = 0; w < 8; w++)
                    for (int k = 0; k < 4; k++)
                        words[w][64*k +: 64] = {$urandom, $urandom};
            end else if (rst_idx >= 0 && mon_cnt == rst_idx && lv_a[sel]) begin
                rst_i = 1'b1;
                #1;
                chk("rst_lane", lane_a[sel], 64'd0);
                chk("rst_flags", {55'd0, lv_a[sel], wr_a[sel], ll_a[sel], busy_a[sel],
                                  done_a[sel], lx_a[sel] | ly_a[sel]}, 64'd0);
                @(posedge clk_i); #1;
                rst_i     = 1'b0;
                wv_a[sel] = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    chk("idle_no_ready", {61'd0, wr_a[sel], lv_a[sel], busy_a[sel]}, 64'd0);
                end
                wv_a[sel] = 1'b0;
                stop = 1;
            end
        end
        if (!stop) begin
            chk("stream_done", 64'(done_seen), 64'd1);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            if (timing) begin
                chk("no_bubble", 64'(last_cyc - first_cyc), 64'(nl - 1));
                chk("first_lat", 64'(first_cyc - acc_cyc), 64'd1);
                chk("done_lat", 64'(done_cyc - acc_cyc), 64'(nl + 1));
            end
            wv_a[sel]    = 1'b0;
            lane_ready_i = 1'b0;
            @(negedge clk_i);
            chk("back_idle", {61'd0, wr_a[sel], lv_a[sel], busy_a[sel]}, 64'd0);
        end
        wv_a[sel]    = 1'b0;
        lane_ready_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        start_a[0]   = 1'b0;
        start_a[1]   = 1'b0;
        wv_a[0]      = 1'b0;
        wv_a[1]      = 1'b0;
        word_i       = '0;
        lane_ready_i = 1'b0;
        #7;
        for (int d = 0; d < 2; d++) begin
            chk("reset_lane", lane_a[d], 64'd0);
            chk("reset_flags", {55'd0, lv_a[d], wr_a[d], ll_a[d], busy_a[d], done_a[d],
                                lx_a[d] | ly_a[d]}, 64'd0);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_stream(0, 1, 0, 0, -1, -1, 1);   // nominal pattern
        run_stream(0, 0, 1, 1, -1, -1, 0);   // backpressure
        run_stream(0, 0, 1, 0, -1, -1, 0);
        run_stream(0, 0, 0, 0, -1, -1, 1);   // seamless reload
        run_stream(0, 0, 1, 0, 10, -1, 0);   // abort at idx 10
        run_stream(0, 0, 1, 0, -1, 13, 0);   // reset at idx 13
        run_stream(0, 1, 0, 0, -1, -1, 1);   // recovery after reset
        run_stream(1, 1, 0, 0, -1, -1, 1);   // NumLanes=4
        run_stream(1, 0, 1, 1, -1, -1, 0);
        run_stream(0, 0, 1, 1, -1, -1, 0);

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
